// File: rtl/uartfifo_blk_pkg.sv
// Shared definitions for the buffered UART block: register map, STATUS/CTRL
// bit positions and the TX sequencer state encoding.
package uartfifo_blk_pkg;

  // Register addresses on the 2-bit bus address
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_RX_OVF      = 4;
  localparam int ST_TX_OVF      = 5;
  localparam int ST_TX_BUSY     = 6;

  // CTRL bit positions
  localparam int CT_IE_RX    = 0;
  localparam int CT_IE_TX    = 1;
  localparam int CT_IE_OVF   = 2;
  localparam int CT_FLUSH_RX = 6;
  localparam int CT_FLUSH_TX = 7;

  // TX sequencer states
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uartfifo_blk_sync_fifo.sv
// Single-clock FIFO with combinational head output, occupancy count and a
// one-cycle flush. A push into a full FIFO is accepted when a pop happens in
// the same cycle; flush overrides both push and pop.
module uartfifo_blk_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy and flush
  always_comb begin
    full    = (count == CNT_FULL);
    empty   = (count == '0);
    do_pop  = pop & ~empty & ~flush;
    do_push = push & (~full | do_pop) & ~flush;
    dout    = mem[rd_ptr];
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uartfifo_blk_uart_core.sv
// 8N1 UART core. One bit period is CLK_FREQ/UART_FREQ clocks. TX starts on a
// tx_write pulse and reports tx_finished after the stop bit; RX samples mid-bit
// and pulses rx_ready with rx_data when a frame with a valid stop bit arrives.
module uartfifo_blk_uart_core #(
  parameter int CLK_FREQ  = 12000000,
  parameter int UART_FREQ = 115200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_finished,
  output logic [7:0] rx_data,
  output logic       rx_ready
);
  localparam int DIV = CLK_FREQ / UART_FREQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic          tx_busy;

  logic          rx_meta;
  logic          rx_sync;
  logic [7:0]    rx_shift;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic          rx_busy;
  logic          rx_sample;

  assign tx      = tx_shift[0];
  assign rx_data = rx_shift;

  // Transmitter: shift out {stop, data, start} LSB first, one bit per period
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tx_shift    <= '1;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_busy     <= 1'b0;
      tx_finished <= 1'b0;
    end else begin
      tx_finished <= 1'b0;
      if (!tx_busy) begin
        if (tx_write) begin
          tx_shift <= {1'b1, tx_data, 1'b0};
          tx_cnt   <= BIT_LAST;
          tx_idx   <= '0;
          tx_busy  <= 1'b1;
        end
      end else if (tx_cnt == '0) begin
        tx_cnt   <= BIT_LAST;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_idx   <= tx_idx + 4'd1;
        if (tx_idx == 4'd9) begin
          tx_busy     <= 1'b0;
          tx_finished <= 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end
    end
  end

  // Receiver control: start-bit detect, mid-bit sampling, stop-bit check
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_busy  <= 1'b0;
      rx_ready <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_ready <= 1'b0;
      if (!rx_busy) begin
        if (!rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_LAST;
          rx_idx  <= '0;
        end
      end else if (rx_cnt == '0) begin
        rx_cnt <= BIT_LAST;
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          if (rx_sync) rx_busy <= 1'b0;
        end else if (rx_idx == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_ready <= rx_sync;
        end
      end else begin
        rx_cnt <= rx_cnt - CNT_ONE;
      end
    end
  end

  assign rx_sample = rx_busy && (rx_cnt == '0) && (rx_idx != 4'd0) && (rx_idx <= 4'd8);

  // Receive data shifter, LSB arrives first
  always_ff @(posedge clk) begin
    if (rx_sample) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

endmodule

// File: rtl/uartfifo_blk.sv
// Buffered UART peripheral on the 8-bit OR-bus: RX/TX FIFOs around the UART
// core, sticky overflow flags, RX-level CTS and a maskable level interrupt.
// The read-data port is named dout because "do" is a reserved word.
module uartfifo_blk
  import uartfifo_blk_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int UART_FREQ = 115200,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int CTS_LEVEL = RX_DEPTH - 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  output logic       tx,
  output logic       cts,
  output logic       irq,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       wren,
  input  logic [7:0] di,
  output logic [7:0] dout
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam logic [RX_CW-1:0] CTS_TH      = RX_CW'(CTS_LEVEL);
  localparam logic [TX_CW-1:0] TX_CNT_FULL = TX_CW'(TX_DEPTH);

  logic             rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;
  logic             tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;

  logic [7:0] core_rx_data;
  logic       core_rx_ready;
  logic       core_tx_finished;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_load;

  tx_state_e  state, state_nxt;

  logic       bus_rd, bus_wr;
  logic       rx_ovf, tx_ovf, rx_ovf_set, tx_ovf_set;
  logic [2:0] ctrl_ie;
  logic       tx_idle;
  logic [7:0] status;
  logic [7:0] rd_mux;
  logic       irq_nxt;
  logic       oe_p1;
  logic [7:0] rdata_p1;

  uartfifo_blk_uart_core #(.CLK_FREQ(CLK_FREQ), .UART_FREQ(UART_FREQ)) u_core (
    .clk         (clk),
    .n_reset     (n_reset),
    .rx          (rx),
    .tx          (tx),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .tx_finished (core_tx_finished),
    .rx_data     (core_rx_data),
    .rx_ready    (core_rx_ready)
  );

  uartfifo_blk_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .din     (core_rx_data),
    .dout    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  uartfifo_blk_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .din     (di),
    .dout    (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // Bus decode, FIFO requests, overflow detection and read-data selection
  always_comb begin
    bus_rd   = cs & ~wren;
    bus_wr   = cs & wren;
    rx_push  = core_rx_ready;
    rx_pop   = bus_rd & (addr == REG_DATA) & ~rx_empty;
    tx_push  = bus_wr & (addr == REG_DATA);
    rx_flush = bus_wr & (addr == REG_CTRL) & di[CT_FLUSH_RX];
    tx_flush = bus_wr & (addr == REG_CTRL) & di[CT_FLUSH_TX];

    rx_ovf_set = rx_push & rx_full & ~rx_pop & ~rx_flush;
    tx_ovf_set = tx_push & tx_full & ~tx_pop & ~tx_flush;

    tx_idle = tx_empty & (state == TX_IDLE);

    status                 = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_NOT_FULL] = (tx_count != TX_CNT_FULL);
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RX_FULL]     = rx_full;
    status[ST_RX_OVF]      = rx_ovf;
    status[ST_TX_OVF]      = tx_ovf;
    status[ST_TX_BUSY]     = (state != TX_IDLE);

    rd_mux = '0;
    case (addr)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {5'b0, ctrl_ie};
      REG_LEVEL:  rd_mux = 8'(rx_count);
      default:    rd_mux = '0;
    endcase

    irq_nxt = (ctrl_ie[CT_IE_RX]  & ~rx_empty) |
              (ctrl_ie[CT_IE_TX]  & tx_idle)   |
              (ctrl_ie[CT_IE_OVF] & (rx_ovf | tx_ovf));
  end

  // TX sequencer next state: fetch a byte, hand it to the core, wait for it
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    tx_load   = 1'b0;
    case (state)
      TX_IDLE: if (!tx_empty) state_nxt = TX_LOAD;
      TX_LOAD: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_load   = 1'b1;
          state_nxt = TX_BUSY;
        end else begin
          state_nxt = TX_IDLE;
        end
      end
      TX_BUSY: if (core_tx_finished) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  // TX sequencer state register
  always_ff @(posedge clk) begin
    if (!n_reset) state <= TX_IDLE;
    else          state <= state_nxt;
  end

  // Hand-off to the core: one-cycle write strobe
  always_ff @(posedge clk) begin
    if (!n_reset) tx_write <= 1'b0;
    else          tx_write <= tx_load;
  end

  // Byte latched for the core at the LOAD step
  always_ff @(posedge clk) begin
    if (tx_load) tx_data <= tx_head;
  end

  // Sticky overflow flags (new events win over write-1-to-clear) and CTRL
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_ovf  <= 1'b0;
      tx_ovf  <= 1'b0;
      ctrl_ie <= '0;
    end else begin
      if (rx_ovf_set)
        rx_ovf <= 1'b1;
      else if (bus_wr && addr == REG_STATUS && di[ST_RX_OVF])
        rx_ovf <= 1'b0;
      if (tx_ovf_set)
        tx_ovf <= 1'b1;
      else if (bus_wr && addr == REG_STATUS && di[ST_TX_OVF])
        tx_ovf <= 1'b0;
      if (bus_wr && addr == REG_CTRL)
        ctrl_ie <= di[2:0];
    end
  end

  // Registered outputs: read-data enable, cts and irq
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      oe_p1 <= 1'b0;
      cts   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      oe_p1 <= bus_rd;
      cts   <= (rx_count >= CTS_TH);
      irq   <= irq_nxt;
    end
  end

  // Read data captured in the access cycle
  always_ff @(posedge clk) begin
    rdata_p1 <= rd_mux;
  end

  assign dout = oe_p1 ? rdata_p1 : 8'h00;

endmodule

// File: tb/tb_uartfifo_blk.sv
// Randomized self-checking bench for uartfifo_blk with a queue-based model of
// the FIFOs and flags, a serial driver for rx and a serial decoder for tx.
module tb_uartfifo_blk;
  localparam int CLK_FREQ  = 800000;
  localparam int UART_FREQ = 100000;
  localparam int DIV       = CLK_FREQ / UART_FREQ;
  localparam int RX_DEPTH  = 8;
  localparam int TX_DEPTH  = 8;
  localparam int CTS_LEVEL = RX_DEPTH - 2;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_LEVEL = 2'd3;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       rx = 1'b1;
  logic       tx, cts, irq;
  logic       cs = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       wren = 1'b0;
  logic [7:0] di = 8'h00;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  logic [8:0] tx_got[$];
  logic       rx_ovf_m = 1'b0;
  logic       tx_ovf_m = 1'b0;
  int         tx_chk = 0;

  always #5 clk = ~clk;

  uartfifo_blk #(
    .CLK_FREQ(CLK_FREQ), .UART_FREQ(UART_FREQ),
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CTS_LEVEL(CTS_LEVEL)
  ) dut (
    .clk(clk), .n_reset(n_reset), .rx(rx), .tx(tx), .cts(cts), .irq(irq),
    .cs(cs), .addr(addr), .wren(wren), .di(di), .dout(dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; wren = 1'b1; addr = a; di = d;
    @(negedge clk);
    cs = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; wren = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  // Serial 8N1 frame into rx plus a short idle gap; model takes the byte
  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV + 4) @(negedge clk);
    if (rx_model.size() < RX_DEPTH) rx_model.push_back(b);
    else rx_ovf_m = 1'b1;
  endtask

  function automatic logic [7:0] exp_status_quiet();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (rx_model.size() != 0);
    s[1] = 1'b1;
    s[2] = 1'b1;
    s[3] = (rx_model.size() == RX_DEPTH);
    s[4] = rx_ovf_m;
    s[5] = tx_ovf_m;
    return s;
  endfunction

  task automatic wait_tx_frames(input int n, input int budget);
    int k;
    k = 0;
    while (tx_got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("tx_frame_count", tx_got.size(), n);
  endtask

  task automatic verify_tx();
    for (int i = tx_chk; i < tx_exp.size(); i++)
      check_eq("tx_frame_byte", (i < tx_got.size()) ? 32'(tx_got[i]) : 32'hDEAD,
               {23'b0, 1'b1, tx_exp[i]});
    tx_chk = tx_exp.size();
  endtask

  task automatic drain_rx(input string tag, input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      bus_read(A_DATA, r);
      check_eq(tag, r, rx_model.pop_front());
    end
  endtask

  // Serial decoder on tx: records {stop_bit, data}
  initial begin
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (n_reset && tx == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        tx_got.push_back({tx, b});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] b;
    int base;
    int k;

    // Reset
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_cts", cts, 1'b0);
    check_eq("rst_dout", dout, 8'h00);
    n_reset = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, r);
    check_eq("t1_status", r, 8'h06);
    @(negedge clk);
    check_eq("t1_dout_unselected", dout, 8'h00);
    bus_read(A_LEVEL, r);
    check_eq("t1_level", r, 8'h00);
    bus_read(A_CTRL, r);
    check_eq("t1_ctrl", r, 8'h00);
    check_eq("t1_tx_idle_line", tx, 1'b1);

    // Two fixed frames, status while busy, then two random frames
    bus_write(A_DATA, 8'h55); tx_exp.push_back(8'h55);
    bus_write(A_DATA, 8'hA3); tx_exp.push_back(8'hA3);
    repeat (3 * DIV) @(negedge clk);
    bus_read(A_STATUS, r);
    check_eq("t2_status_busy", r, 8'h42);
    wait_tx_frames(2, 30 * DIV);
    repeat (2 * DIV) @(negedge clk);
    bus_read(A_STATUS, r);
    check_eq("t2_status_done", r, 8'h06);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, b);
      tx_exp.push_back(b);
    end
    wait_tx_frames(4, 30 * DIV);
    repeat (2 * DIV) @(negedge clk);
    verify_tx();

    // RX: fixed then random bytes
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    bus_read(A_LEVEL, r);
    check_eq("t3_level3", r, 8'd3);
    drain_rx("t3_rx_data", 3);
    bus_read(A_DATA, r);
    check_eq("t3_rx_empty_read", r, 8'h00);
    bus_read(A_LEVEL, r);
    check_eq("t3_level0", r, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    bus_read(A_STATUS, r);
    check_eq("t3_status_rx", r, exp_status_quiet());
    drain_rx("t3_rx_rand", 3);

    // RX overflow and cts threshold
    for (int i = 0; i < RX_DEPTH + 1; i++) begin
      send_byte(8'($urandom));
      check_eq("t4_cts", cts, 32'(rx_model.size() >= CTS_LEVEL));
    end
    bus_read(A_STATUS, r);
    check_eq("t4_status_ovf", r, exp_status_quiet());
    check_eq("t4_irq_masked", irq, 1'b0);
    bus_write(A_STATUS, 8'h10); rx_ovf_m = 1'b0;
    bus_read(A_STATUS, r);
    check_eq("t4_status_clr", r, exp_status_quiet());
    bus_read(A_LEVEL, r);
    check_eq("t4_level_full", r, RX_DEPTH);
    drain_rx("t4_rx_data", RX_DEPTH);
    repeat (2) @(negedge clk);
    check_eq("t4_cts_released", cts, 1'b0);

    // Interrupts and flush
    bus_write(A_CTRL, 8'h01);
    bus_read(A_CTRL, r);
    check_eq("t5_ctrl_rd", r, 8'h01);
    check_eq("t5_irq_quiet", irq, 1'b0);
    send_byte(8'($urandom));
    check_eq("t5_irq_rx", irq, 1'b1);
    drain_rx("t5_rx_data", 1);
    @(negedge clk);
    check_eq("t5_irq_cleared", irq, 1'b0);
    bus_write(A_CTRL, 8'h02);
    @(negedge clk);
    check_eq("t5_irq_txidle", irq, 1'b1);
    bus_write(A_CTRL, 8'h04);
    @(negedge clk);
    check_eq("t5_irq_ovf_none", irq, 1'b0);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    bus_write(A_CTRL, 8'h40);
    rx_model.delete();
    bus_read(A_LEVEL, r);
    check_eq("t5_flush_level", r, 8'h00);
    bus_read(A_CTRL, r);
    check_eq("t5_ctrl_strobe_rd", r, 8'h00);

    // TX overflow: TX_DEPTH+2 back-to-back writes
    base = tx_got.size();
    for (int i = 0; i < TX_DEPTH + 2; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, b);
      if (i < TX_DEPTH + 1) tx_exp.push_back(b);
      else tx_ovf_m = 1'b1;
    end
    bus_read(A_STATUS, r);
    check_eq("t6_tx_ovf", 32'(r[5]), 32'(tx_ovf_m));
    check_eq("t6_tx_busy", 32'(r[6]), 1);
    wait_tx_frames(base + TX_DEPTH + 1, (TX_DEPTH + 3) * 12 * DIV);
    repeat (30 * DIV) @(negedge clk);
    check_eq("t6_exact_frames", tx_got.size(), base + TX_DEPTH + 1);
    verify_tx();
    bus_write(A_STATUS, 8'h20); tx_ovf_m = 1'b0;
    bus_read(A_STATUS, r);
    check_eq("t6_status_clr", r, exp_status_quiet());

    // Reset in the middle of a frame
    send_byte(8'($urandom));
    bus_write(A_DATA, 8'($urandom));
    k = 0;
    while (tx !== 1'b0 && k < 20 * DIV) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_frame_started", tx, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_tx", tx, 1'b1);
    check_eq("t6_rst_irq", irq, 1'b0);
    check_eq("t6_rst_cts", cts, 1'b0);
    n_reset = 1'b1;
    rx_model.delete();
    rx_ovf_m = 1'b0;
    tx_ovf_m = 1'b0;
    @(negedge clk);
    bus_read(A_STATUS, r);
    check_eq("t6_rst_status", r, 8'h06);
    bus_read(A_LEVEL, r);
    check_eq("t6_rst_level", r, 8'h00);
    repeat (12 * DIV) @(negedge clk);
    check_eq("t6_tx_stays_high", tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
